// File: rtl/countdown_timer_if.sv
// Stage-timer control/status bundle: control pulses and levels in, BCD/7-seg status out.
// Latency: none (pure wiring); all timing is owned by countdown_timer.
// Backpressure: none; controls are sampled every cycle, status is always valid.
//
// Ports (signals):
//   start_pulse, pause, game_over, bonus_pulse : controller -> timer
//   time_digits, ss, running, low_time, expired_pulse : timer -> controller/displays
interface countdown_timer_if #(
    parameter int DIGIT_AMOUNT = 2
);
    logic                               start_pulse;
    logic                               pause;
    logic                               game_over;
    logic                               bonus_pulse;
    logic [DIGIT_AMOUNT-1:0][3:0]       time_digits;
    logic [DIGIT_AMOUNT-1:0][6:0]       ss;
    logic                               running;
    logic                               low_time;
    logic                               expired_pulse;

    // Game controller side.
    modport master (
        output start_pulse,
        output pause,
        output game_over,
        output bonus_pulse,
        input  time_digits,
        input  ss,
        input  running,
        input  low_time,
        input  expired_pulse
    );

    // Timer side.
    modport slave (
        input  start_pulse,
        input  pause,
        input  game_over,
        input  bonus_pulse,
        output time_digits,
        output ss,
        output running,
        output low_time,
        output expired_pulse
    );
endinterface

// File: rtl/countdown_timer.sv
// Stage countdown timer: loads a start time, counts down once per tick, adds bonus time, flags expiry.
// Latency: state/running/low_time/expired_pulse update on the edge sampling the inputs; time_digits one edge later.
// Backpressure: none; every control input is acted on in the cycle it is sampled.
//
// Ports:
//   clk    : system clock
//   resetN : asynchronous active-low reset
//   tmr    : countdown_timer_if.slave (controls in, BCD digits / 7-seg codes / status out)
module countdown_timer #(
    parameter int DIGIT_AMOUNT       = 2,
    parameter int CLKS_PER_TICK      = 31_500_000,
    parameter int START_SECONDS      = 60,
    parameter int BONUS_SECONDS      = 5,
    parameter int LOW_TIME_THRESHOLD = 10
) (
    input  logic              clk,
    input  logic              resetN,
    countdown_timer_if.slave  tmr
);

    localparam int MAX = 10**DIGIT_AMOUNT - 1;
    localparam int CW  = $clog2(MAX + 1);
    localparam int PW  = $clog2(CLKS_PER_TICK);

    localparam logic [CW-1:0] MAX_C   = CW'(MAX);
    localparam logic [CW-1:0] START_C = CW'(START_SECONDS);
    localparam logic [CW-1:0] BONUS_C = CW'(BONUS_SECONDS);
    // A threshold above MAX behaves exactly like MAX, so clamp it to fit the count width.
    localparam logic [CW-1:0] LOW_C   = CW'((LOW_TIME_THRESHOLD > MAX) ? MAX : LOW_TIME_THRESHOLD);
    localparam logic [PW-1:0] LAST_C  = PW'(CLKS_PER_TICK - 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RUNNING = 2'd1,
        PAUSED  = 2'd2,
        EXPIRED = 2'd3
    } state_t;

    state_t                         state;
    logic [CW-1:0]                  count;
    logic [PW-1:0]                  presc;
    logic [DIGIT_AMOUNT-1:0][3:0]   digits_q;
    logic [DIGIT_AMOUNT-1:0][3:0]   digits_nxt;
    logic                           running_q;
    logic                           low_q;
    logic                           expired_q;

    logic                           active;
    logic                           advance;
    logic                           tick;
    logic [CW:0]                    sum;
    logic [CW-1:0]                  count_upd;

    // 7-segment code, active-low segments ordered {g,f,e,d,c,b,a}.
    function automatic logic [6:0] hexss(input logic [3:0] d);
        logic [6:0] seg;
        case (d)
            4'h0:    seg = 7'b1000000;
            4'h1:    seg = 7'b1111001;
            4'h2:    seg = 7'b0100100;
            4'h3:    seg = 7'b0110000;
            4'h4:    seg = 7'b0011001;
            4'h5:    seg = 7'b0010010;
            4'h6:    seg = 7'b0000010;
            4'h7:    seg = 7'b1111000;
            4'h8:    seg = 7'b0000000;
            4'h9:    seg = 7'b0010000;
            4'hA:    seg = 7'b0001000;
            4'hB:    seg = 7'b0000011;
            4'hC:    seg = 7'b1000110;
            4'hD:    seg = 7'b0100001;
            4'hE:    seg = 7'b0000110;
            default: seg = 7'b0001110;
        endcase
        return seg;
    endfunction

    // Count arithmetic shared by RUNNING and PAUSED. A paused cycle never ticks; a
    // PAUSED cycle with pause released counts as a normal running cycle, so the
    // prescaler picks up exactly where it froze.
    always_comb begin
        active    = (state == RUNNING) || (state == PAUSED);
        advance   = active && !tmr.pause;
        tick      = advance && (presc == LAST_C);
        // One extra bit holds count + bonus before saturation. count is never 0
        // while active, so subtracting the tick cannot underflow.
        sum       = {1'b0, count}
                  + (tmr.bonus_pulse ? {1'b0, BONUS_C} : {(CW+1){1'b0}})
                  - {{CW{1'b0}}, tick};
        count_upd = (sum > {1'b0, MAX_C}) ? MAX_C : sum[CW-1:0];
    end

    // Binary to BCD by constant division per digit position.
    for (genvar i = 0; i < DIGIT_AMOUNT; i++) begin : g_bcd
        localparam logic [31:0] DIV = 32'(10**i);
        assign digits_nxt[i] = 4'((32'(count) / DIV) % 32'd10);
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state     <= IDLE;
            count     <= '0;
            presc     <= '0;
            digits_q  <= '0;
            running_q <= 1'b0;
            low_q     <= 1'b0;
            expired_q <= 1'b0;
        end else begin
            // Display registers trail the count by one edge.
            digits_q  <= digits_nxt;
            expired_q <= 1'b0;

            if (tmr.start_pulse) begin
                state     <= RUNNING;
                count     <= START_C;
                presc     <= '0;
                running_q <= 1'b1;
                low_q     <= (START_C <= LOW_C);
            end else if (tmr.game_over) begin
                // Count is frozen so the display keeps the final time.
                state     <= IDLE;
                running_q <= 1'b0;
                low_q     <= 1'b0;
            end else if (active) begin
                count <= count_upd;
                if (tmr.pause) begin
                    state     <= PAUSED;
                    running_q <= 1'b0;
                    low_q     <= 1'b0;
                end else begin
                    presc <= tick ? '0 : presc + 1'b1;
                    if (count_upd == '0) begin
                        // Leaving the active states guarantees a single pulse per start.
                        state     <= EXPIRED;
                        running_q <= 1'b0;
                        low_q     <= 1'b0;
                        expired_q <= 1'b1;
                    end else begin
                        state     <= RUNNING;
                        running_q <= 1'b1;
                        low_q     <= (count_upd <= LOW_C);
                    end
                end
            end
            // IDLE / EXPIRED without start: everything holds.
        end
    end

    always_comb begin
        tmr.ss = '0;
        for (int i = 0; i < DIGIT_AMOUNT; i++) begin
            tmr.ss[i] = hexss(digits_q[i]);
        end
    end

    assign tmr.time_digits   = digits_q;
    assign tmr.running       = running_q;
    assign tmr.low_time      = low_q;
    assign tmr.expired_pulse = expired_q;

endmodule

// File: tb/tb_countdown_timer.sv
// Testbench for countdown_timer: directed scenarios plus a randomized run against a behavioural model.
// Latency: model predicts outputs one edge after each sampled input set; digits trail the count by one edge.
// Backpressure: none.
module tb_countdown_timer;

    localparam int TICK  = 4;
    localparam int START = 12;
    localparam int BONUS = 5;
    localparam int LOW   = 10;
    localparam int MAXV  = 99;

    logic clk;
    logic resetN;

    countdown_timer_if #(.DIGIT_AMOUNT(2)) cd_if ();

    countdown_timer #(
        .DIGIT_AMOUNT       (2),
        .CLKS_PER_TICK      (TICK),
        .START_SECONDS      (START),
        .BONUS_SECONDS      (BONUS),
        .LOW_TIME_THRESHOLD (LOW)
    ) dut (
        .clk    (clk),
        .resetN (resetN),
        .tmr    (cd_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Behavioural model: mode 0 idle, 1 running, 2 paused, 3 expired.
    int m_mode;
    int m_count;
    int m_shown;        // value the digit display shows (count one edge earlier)
    int m_run_cycles;   // un-paused active cycles since the last start
    bit m_pulse;

    // Reference 7-segment table, active-low {g,f,e,d,c,b,a}.
    function automatic logic [6:0] seg_of(input int d);
        case (d)
            0: return 7'b1000000;
            1: return 7'b1111001;
            2: return 7'b0100100;
            3: return 7'b0110000;
            4: return 7'b0011001;
            5: return 7'b0010010;
            6: return 7'b0000010;
            7: return 7'b1111000;
            8: return 7'b0000000;
            default: return 7'b0010000;
        endcase
    endfunction

    function automatic logic [7:0] to_bcd(input int v);
        logic [3:0] hi;
        logic [3:0] lo;
        hi = 4'(v / 10);
        lo = 4'(v % 10);
        return {hi, lo};
    endfunction

    task automatic model_reset();
        m_mode       = 0;
        m_count      = 0;
        m_shown      = 0;
        m_run_cycles = 0;
        m_pulse      = 1'b0;
    endtask

    // Drive one cycle of inputs (at a negedge), advance the model at the posedge,
    // return at the following negedge where outputs are sampled.
    task automatic step(input bit s, input bit p, input bit g, input bit b);
        int nv;
        cd_if.start_pulse = s;
        cd_if.pause       = p;
        cd_if.game_over   = g;
        cd_if.bonus_pulse = b;
        @(posedge clk);
        m_shown = m_count;
        m_pulse = 1'b0;
        if (s) begin
            m_count      = START;
            m_run_cycles = 0;
            m_mode       = 1;
        end else if (g) begin
            m_mode = 0;
        end else if (m_mode == 1 || m_mode == 2) begin
            nv = m_count + (b ? BONUS : 0);
            if (p) begin
                m_mode = 2;
            end else begin
                m_run_cycles++;
                if (m_run_cycles % TICK == 0) nv = nv - 1;
                m_mode = 1;
            end
            if (nv > MAXV) nv = MAXV;
            m_count = nv;
            if (!p && nv == 0) begin
                m_mode  = 3;
                m_pulse = 1'b1;
            end
        end
        @(negedge clk);
    endtask

    task automatic test_reset();
        resetN = 1'b0;
        cd_if.start_pulse = 1'b0;
        cd_if.pause       = 1'b0;
        cd_if.game_over   = 1'b0;
        cd_if.bonus_pulse = 1'b0;
        model_reset();
        repeat (3) @(negedge clk);
        checks++; if (cd_if.running !== 1'b0) begin errors++; $display("FAIL reset_running got=%b want=0", cd_if.running); end
        checks++; if (cd_if.low_time !== 1'b0) begin errors++; $display("FAIL reset_low got=%b want=0", cd_if.low_time); end
        checks++; if (cd_if.expired_pulse !== 1'b0) begin errors++; $display("FAIL reset_expired got=%b want=0", cd_if.expired_pulse); end
        checks++; if (cd_if.time_digits !== 8'h00) begin errors++; $display("FAIL reset_digits got=%h want=00", cd_if.time_digits); end
        checks++; if (cd_if.ss[0] !== seg_of(0) || cd_if.ss[1] !== seg_of(0)) begin errors++; $display("FAIL reset_ss got=%b_%b want=%b_%b", cd_if.ss[1], cd_if.ss[0], seg_of(0), seg_of(0)); end
        resetN = 1'b1;
        step(0, 0, 0, 0);
        checks++; if (cd_if.running !== 1'b0) begin errors++; $display("FAIL reset_idle_hold got=%b want=0", cd_if.running); end
    endtask

    task automatic test_countdown();
        int pulses = 0;
        int pulse_edge = -1;
        step(1, 0, 0, 0);
        checks++; if (cd_if.running !== 1'b1) begin errors++; $display("FAIL cd_start_running got=%b want=1", cd_if.running); end
        checks++; if (cd_if.time_digits !== 8'h00) begin errors++; $display("FAIL cd_digit_lag got=%h want=00", cd_if.time_digits); end
        for (int e = 1; e <= 68; e++) begin
            step(0, 0, 0, 0);
            if (cd_if.expired_pulse === 1'b1) begin pulses++; pulse_edge = e; end
            if (e == 1) begin
                checks++; if (cd_if.time_digits !== 8'h12) begin errors++; $display("FAIL cd_digits12 got=%h want=12", cd_if.time_digits); end
                checks++; if (cd_if.ss[1] !== seg_of(1) || cd_if.ss[0] !== seg_of(2)) begin errors++; $display("FAIL cd_ss12 got=%b_%b want=%b_%b", cd_if.ss[1], cd_if.ss[0], seg_of(1), seg_of(2)); end
            end
            if (e == 5) begin
                checks++; if (cd_if.time_digits !== 8'h11) begin errors++; $display("FAIL cd_digits11 got=%h want=11", cd_if.time_digits); end
            end
            if (e == 7) begin
                checks++; if (cd_if.low_time !== 1'b0) begin errors++; $display("FAIL cd_low_at11 got=%b want=0", cd_if.low_time); end
            end
            if (e == 8) begin
                checks++; if (cd_if.low_time !== 1'b1) begin errors++; $display("FAIL cd_low_at10 got=%b want=1", cd_if.low_time); end
            end
            if (e == 48) begin
                checks++; if (cd_if.expired_pulse !== 1'b1) begin errors++; $display("FAIL cd_expire got=%b want=1", cd_if.expired_pulse); end
                checks++; if (cd_if.running !== 1'b0) begin errors++; $display("FAIL cd_expire_running got=%b want=0", cd_if.running); end
            end
        end
        checks++; if (pulses !== 1 || pulse_edge !== 48) begin errors++; $display("FAIL cd_pulse_count got=%0d@%0d want=1@48", pulses, pulse_edge); end
        checks++; if (cd_if.time_digits !== 8'h00) begin errors++; $display("FAIL cd_hold_zero got=%h want=00", cd_if.time_digits); end
    endtask

    task automatic test_pause();
        step(1, 0, 0, 0);
        for (int e = 1; e <= 19; e++) begin
            step(0, (e >= 6 && e <= 15), 0, 0);
            if (e == 6) begin
                checks++; if (cd_if.running !== 1'b0) begin errors++; $display("FAIL pause_running got=%b want=0", cd_if.running); end
            end
            if (e == 15) begin
                checks++; if (cd_if.time_digits !== 8'h11) begin errors++; $display("FAIL pause_hold got=%h want=11", cd_if.time_digits); end
            end
            if (e == 16) begin
                checks++; if (cd_if.running !== 1'b1) begin errors++; $display("FAIL pause_resume got=%b want=1", cd_if.running); end
            end
            if (e == 18) begin
                checks++; if (cd_if.time_digits !== 8'h11) begin errors++; $display("FAIL pause_presc_frozen got=%h want=11", cd_if.time_digits); end
                checks++; if (cd_if.low_time !== 1'b1) begin errors++; $display("FAIL pause_low got=%b want=1", cd_if.low_time); end
            end
            if (e == 19) begin
                checks++; if (cd_if.time_digits !== 8'h10) begin errors++; $display("FAIL pause_first_dec got=%h want=10", cd_if.time_digits); end
            end
        end
    endtask

    task automatic test_bonus();
        int pulses = 0;
        step(1, 0, 0, 0);
        for (int e = 1; e <= 20; e++) step(0, 0, 0, 1);
        step(0, 0, 0, 0);
        checks++; if (cd_if.time_digits !== 8'h99) begin errors++; $display("FAIL bonus_saturate got=%h want=99", cd_if.time_digits); end
        checks++; if (cd_if.ss[1] !== seg_of(9) || cd_if.ss[0] !== seg_of(9)) begin errors++; $display("FAIL bonus_ss99 got=%b_%b want=%b_%b", cd_if.ss[1], cd_if.ss[0], seg_of(9), seg_of(9)); end
        // Bonus landing on the tick that would take the count from 1 to 0.
        step(1, 0, 0, 0);
        for (int e = 1; e <= 49; e++) begin
            step(0, 0, 0, (e == 48));
            if (cd_if.expired_pulse === 1'b1) pulses++;
        end
        checks++; if (pulses !== 0) begin errors++; $display("FAIL bonus_tick_no_expire got=%0d want=0", pulses); end
        checks++; if (cd_if.time_digits !== 8'h05) begin errors++; $display("FAIL bonus_tick_count got=%h want=05", cd_if.time_digits); end
        checks++; if (cd_if.running !== 1'b1) begin errors++; $display("FAIL bonus_tick_running got=%b want=1", cd_if.running); end
    endtask

    task automatic test_game_over();
        step(1, 0, 0, 0);
        for (int e = 1; e <= 20; e++) step(0, 0, 0, 0);
        step(0, 0, 1, 0);
        checks++; if (cd_if.running !== 1'b0) begin errors++; $display("FAIL go_running got=%b want=0", cd_if.running); end
        for (int e = 0; e < 6; e++) begin
            step(0, e[0], 1, 1);
            checks++; if (cd_if.time_digits !== 8'h07 || cd_if.running !== 1'b0) begin errors++; $display("FAIL go_hold got=%h/%b want=07/0", cd_if.time_digits, cd_if.running); end
        end
        for (int e = 0; e < 3; e++) step(0, 0, 0, 1);
        checks++; if (cd_if.time_digits !== 8'h07 || cd_if.low_time !== 1'b0) begin errors++; $display("FAIL go_idle_bonus got=%h/%b want=07/0", cd_if.time_digits, cd_if.low_time); end
        step(1, 0, 1, 0);
        checks++; if (cd_if.running !== 1'b1) begin errors++; $display("FAIL go_restart got=%b want=1", cd_if.running); end
        step(0, 0, 0, 0);
        checks++; if (cd_if.time_digits !== 8'h12) begin errors++; $display("FAIL go_restart_count got=%h want=12", cd_if.time_digits); end
    endtask

    task automatic test_reset_midcount();
        step(1, 0, 0, 0);
        for (int e = 1; e <= 13; e++) step(0, 0, 0, 0);
        checks++; if (cd_if.time_digits !== 8'h09 || cd_if.low_time !== 1'b1) begin errors++; $display("FAIL rst_pre got=%h/%b want=09/1", cd_if.time_digits, cd_if.low_time); end
        #2 resetN = 1'b0;
        #1;
        checks++; if (cd_if.running !== 1'b0 || cd_if.low_time !== 1'b0 || cd_if.expired_pulse !== 1'b0) begin errors++; $display("FAIL rst_async_flags got=%b%b%b want=000", cd_if.running, cd_if.low_time, cd_if.expired_pulse); end
        checks++; if (cd_if.time_digits !== 8'h00 || cd_if.ss[0] !== seg_of(0)) begin errors++; $display("FAIL rst_async_digits got=%h want=00", cd_if.time_digits); end
        model_reset();
        @(negedge clk);
        resetN = 1'b1;
        for (int e = 0; e < 6; e++) begin
            step(0, 0, 0, 1);
            checks++; if (cd_if.running !== 1'b0 || cd_if.time_digits !== 8'h00 || cd_if.expired_pulse !== 1'b0) begin errors++; $display("FAIL rst_post_idle got=%b/%h/%b want=0/00/0", cd_if.running, cd_if.time_digits, cd_if.expired_pulse); end
        end
    endtask

    task automatic test_random();
        bit p_lvl = 1'b0;
        bit g_lvl = 1'b0;
        bit s;
        bit b;
        logic [7:0] exp_dig;
        logic       exp_run;
        logic       exp_low;
        step(1, 0, 0, 0);
        for (int n = 0; n < 600; n++) begin
            if ($urandom_range(0, 7) == 0)  p_lvl = ~p_lvl;
            if ($urandom_range(0, 24) == 0) g_lvl = ~g_lvl;
            s = ($urandom_range(0, 59) == 0);
            b = ($urandom_range(0, 5) == 0);
            step(s, p_lvl, g_lvl, b);
            exp_dig = to_bcd(m_shown);
            exp_run = (m_mode == 1);
            exp_low = exp_run && (m_count <= LOW);
            checks++; if (cd_if.time_digits !== exp_dig) begin errors++; $display("FAIL rnd_digits n=%0d got=%h want=%h", n, cd_if.time_digits, exp_dig); end
            checks++; if (cd_if.ss[1] !== seg_of(int'(exp_dig[7:4])) || cd_if.ss[0] !== seg_of(int'(exp_dig[3:0]))) begin errors++; $display("FAIL rnd_ss n=%0d got=%b_%b", n, cd_if.ss[1], cd_if.ss[0]); end
            checks++; if (cd_if.running !== exp_run) begin errors++; $display("FAIL rnd_running n=%0d got=%b want=%b", n, cd_if.running, exp_run); end
            checks++; if (cd_if.low_time !== exp_low) begin errors++; $display("FAIL rnd_low n=%0d got=%b want=%b", n, cd_if.low_time, exp_low); end
            checks++; if (cd_if.expired_pulse !== m_pulse) begin errors++; $display("FAIL rnd_expired n=%0d got=%b want=%b", n, cd_if.expired_pulse, m_pulse); end
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_countdown();
        test_pause();
        test_bonus();
        test_game_over();
        test_reset_midcount();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
